// File: rtl/csr_master_arb_if.sv
// Requester and CSR-bus signal bundle for csr_master_arb.
// The master modport is the arbiter's view; slave is the requester/decoder side.
interface csr_master_arb_if #(
   parameter int NREQ = 3,
   parameter int AW   = 14,
   parameter int DW   = 64
);
   logic [NREQ-1:0]    iREQ_WR;
   logic [NREQ-1:0]    iREQ_RD;
   logic [NREQ*AW-1:0] iREQ_ADDR;
   logic [NREQ*DW-1:0] iREQ_WDATA;
   logic [NREQ-1:0]    oREQ_ACK;
   logic               oREQ_ERR;
   logic [DW-1:0]      oREQ_RDATA;
   logic               oMM_WR_EN;
   logic               oMM_RD_EN;
   logic [AW-1:0]      oMM_ADDR;
   logic [DW-1:0]      oMM_WR_DATA;
   logic [DW-1:0]      iMM_RD_DATA;
   logic               iMM_RD_DATA_V;
   logic               oBUSY;

   modport master (
      input  iREQ_WR, iREQ_RD, iREQ_ADDR, iREQ_WDATA, iMM_RD_DATA, iMM_RD_DATA_V,
      output oREQ_ACK, oREQ_ERR, oREQ_RDATA, oMM_WR_EN, oMM_RD_EN, oMM_ADDR,
             oMM_WR_DATA, oBUSY
   );

   modport slave (
      output iREQ_WR, iREQ_RD, iREQ_ADDR, iREQ_WDATA, iMM_RD_DATA, iMM_RD_DATA_V,
      input  oREQ_ACK, oREQ_ERR, oREQ_RDATA, oMM_WR_EN, oMM_RD_EN, oMM_ADDR,
             oMM_WR_DATA, oBUSY
   );
endinterface

// File: rtl/csr_master_arb.sv
// Round-robin arbiter sharing one CSR bus among NREQ requesters, one transaction
// at a time, with a post-write gap and a read timeout that completes with an error.
module csr_master_arb #(
   parameter int            NREQ       = 3,
   parameter int            AW         = 14,
   parameter int            DW         = 64,
   parameter int            RD_TIMEOUT = 1023,
   parameter int            WR_GAP     = 8,
   parameter logic [DW-1:0] ERR_DATA   = 64'hDEAD_BEEF_0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   csr_master_arb_if.master bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [15:0] TO_LAST  = 16'(RD_TIMEOUT - 1);
   localparam logic [7:0]  GAP_LAST = 8'(WR_GAP - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_RD_WAIT,
      ST_WR_GAP,
      ST_DONE
   } state_t;

   state_t          state_reg;
   logic [PW-1:0]   ptr_reg;
   logic [PW-1:0]   gnt_reg;
   logic            is_rd_reg;
   logic [AW-1:0]   addr_reg;
   logic [DW-1:0]   wdata_reg;
   logic [15:0]     cnt_reg;
   logic [7:0]      gap_reg;
   logic [NREQ-1:0] ack_reg;
   logic            err_reg;
   logic [DW-1:0]   rdata_reg;
   logic            wr_en_reg;
   logic            rd_en_reg;

   logic [AW-1:0]   req_addr  [NREQ];
   logic [DW-1:0]   req_wdata [NREQ];
   logic [PW-1:0]   rot_idx   [NREQ];
   logic [NREQ-1:0] cand;
   logic            any_cand;
   logic [PW-1:0]   pick;
   logic [PW-1:0]   ptr_next;

   // rot_idx[k] is the requester k places after the round-robin pointer
   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign req_addr[gi]  = bus.iREQ_ADDR[gi*AW +: AW];
         assign req_wdata[gi] = bus.iREQ_WDATA[gi*DW +: DW];
         assign rot_idx[gi]   = PW'((int'(ptr_reg) + gi) % NREQ);
      end
   endgenerate

   assign cand = bus.iREQ_WR | bus.iREQ_RD;

   always_comb begin
      any_cand = |cand;
      pick     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (cand[rot_idx[k]]) pick = rot_idx[k];
      end
      ptr_next = PW'((int'(pick) + 1) % NREQ);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         ptr_reg   <= '0;
         gnt_reg   <= '0;
         is_rd_reg <= 1'b0;
         addr_reg  <= '0;
         wdata_reg <= '0;
         cnt_reg   <= '0;
         gap_reg   <= '0;
         ack_reg   <= '0;
         err_reg   <= 1'b0;
         rdata_reg <= '0;
         wr_en_reg <= 1'b0;
         rd_en_reg <= 1'b0;
      end else begin
         ack_reg   <= '0;
         err_reg   <= 1'b0;
         wr_en_reg <= 1'b0;
         rd_en_reg <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (any_cand) begin
                  // A requester raising both WR and RD is served as a read first
                  gnt_reg   <= pick;
                  ptr_reg   <= ptr_next;
                  addr_reg  <= req_addr[pick];
                  wdata_reg <= req_wdata[pick];
                  is_rd_reg <= bus.iREQ_RD[pick];
                  rd_en_reg <= bus.iREQ_RD[pick];
                  wr_en_reg <= ~bus.iREQ_RD[pick];
                  state_reg <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (is_rd_reg) begin
                  cnt_reg   <= '0;
                  state_reg <= ST_RD_WAIT;
               end else begin
                  ack_reg   <= NREQ'(1) << gnt_reg;
                  gap_reg   <= '0;
                  state_reg <= (WR_GAP == 0) ? ST_DONE : ST_WR_GAP;
               end
            end
            ST_RD_WAIT: begin
               cnt_reg <= cnt_reg + 16'd1;
               if (bus.iMM_RD_DATA_V) begin
                  rdata_reg <= bus.iMM_RD_DATA;
                  ack_reg   <= NREQ'(1) << gnt_reg;
                  state_reg <= ST_DONE;
               end else if (cnt_reg == TO_LAST) begin
                  rdata_reg <= {ERR_DATA[DW-1:AW], addr_reg};
                  err_reg   <= 1'b1;
                  ack_reg   <= NREQ'(1) << gnt_reg;
                  state_reg <= ST_DONE;
               end
            end
            ST_WR_GAP: begin
               // The DONE cycle after the gap gives the writer time to drop its request
               gap_reg <= gap_reg + 8'd1;
               if (gap_reg == GAP_LAST) state_reg <= ST_DONE;
            end
            ST_DONE: state_reg <= ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   assign bus.oREQ_ACK    = ack_reg;
   assign bus.oREQ_ERR    = err_reg;
   assign bus.oREQ_RDATA  = rdata_reg;
   assign bus.oMM_WR_EN   = wr_en_reg;
   assign bus.oMM_RD_EN   = rd_en_reg;
   assign bus.oMM_ADDR    = addr_reg;
   assign bus.oMM_WR_DATA = wdata_reg;
   assign bus.oBUSY       = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_csr_master_arb.sv
// Randomized bench for csr_master_arb against a transaction-level model of
// grant order, strobe timing, completion timing and returned data.
module tb_csr_master_arb;
   localparam int NREQ = 3;
   localparam int AW   = 14;
   localparam int DW   = 64;
   localparam int T    = 16;
   localparam int G    = 8;
   localparam logic [63:0] ERRD = 64'hDEAD_BEEF_0000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   csr_master_arb_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

   csr_master_arb #(
      .NREQ(NREQ), .AW(AW), .DW(DW), .RD_TIMEOUT(T), .WR_GAP(G), .ERR_DATA(ERRD)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int checks   = 0;
   int failures = 0;

   int            m_ptr;
   logic [63:0]   m_rdata, m_addr, m_wdata;
   logic [AW-1:0] r_addr  [NREQ];
   logic [DW-1:0] r_wdata [NREQ];
   logic [NREQ-1:0] r_wr, r_rd;
   int            r_reps  [NREQ];
   int            gnt_log [$];

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic drive_reqs();
      bus.iREQ_WR = r_wr;
      bus.iREQ_RD = r_rd;
      for (int i = 0; i < NREQ; i++) begin
         bus.iREQ_ADDR[i*AW +: AW]  = r_addr[i];
         bus.iREQ_WDATA[i*DW +: DW] = r_wdata[i];
      end
   endtask

   task automatic clear_reqs();
      r_wr = '0;
      r_rd = '0;
      for (int i = 0; i < NREQ; i++) begin
         r_addr[i]  = '0;
         r_wdata[i] = '0;
         r_reps[i]  = 1;
      end
   endtask

   function automatic int model_pick(input logic [NREQ-1:0] pend, input int ptr);
      for (int k = 0; k < NREQ; k++)
         if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return 0;
   endfunction

   // Runs until every pending request is completed; called at a negedge with the DUT idle.
   // force_l > 0 fixes the decoder read latency, otherwise it is random.
   task automatic run_round(input int force_l);
      int t, s, g, lat, exp_ack, exp_issue, busy_end, tail_end, dv_t;
      bit is_rd, exp_err;
      logic [63:0] exp_rd, dv_data;
      logic [NREQ-1:0] pend, expv;
      drive_reqs();
      pend      = r_wr | r_rd;
      exp_issue = (pend != '0) ? 1 : -1;
      exp_ack = -1; s = -1; busy_end = -1; tail_end = -1; dv_t = -1;
      g = 0; lat = 0; is_rd = 0; exp_err = 0; exp_rd = '0; dv_data = '0;
      for (t = 0; t < 600; t++) begin
         bus.iMM_RD_DATA_V = (t == dv_t);
         bus.iMM_RD_DATA   = (t == dv_t) ? dv_data : {$urandom(), $urandom()};
         if (t == exp_issue) begin
            g     = model_pick(pend, m_ptr);
            is_rd = r_rd[g];
            check_eq("issue_wr", bus.oMM_WR_EN, !is_rd);
            check_eq("issue_rd", bus.oMM_RD_EN, is_rd);
            m_addr  = r_addr[g];
            m_wdata = r_wdata[g];
            m_ptr   = (g + 1) % NREQ;
            s = t;
            gnt_log.push_back(g);
            if (is_rd) begin
               lat     = (force_l > 0) ? force_l : $urandom_range(1, T + 3);
               dv_t    = t + lat;
               dv_data = {$urandom(), $urandom()};
               exp_ack = t + ((lat <= T) ? lat : T) + 1;
               exp_err = (lat > T);
               exp_rd  = exp_err ? ((ERRD & ~((64'd1 << AW) - 64'd1)) | 64'(r_addr[g])) : dv_data;
               busy_end = exp_ack;
            end else begin
               exp_ack  = t + 1;
               exp_err  = 0;
               busy_end = t + G + 1;
            end
            exp_issue = -1;
         end else begin
            check_eq("no_strobe", {bus.oMM_WR_EN, bus.oMM_RD_EN}, 2'b00);
         end
         check_eq("addr_hold", bus.oMM_ADDR, m_addr);
         check_eq("wdata_hold", bus.oMM_WR_DATA, m_wdata);
         check_eq("busy", bus.oBUSY, (s >= 0 && t >= s && t <= busy_end));
         if (t == exp_ack) begin
            expv    = '0;
            expv[g] = 1'b1;
            check_eq("ack", bus.oREQ_ACK, expv);
            check_eq("err", bus.oREQ_ERR, exp_err);
            if (is_rd) m_rdata = exp_rd;
            check_eq("rdata", bus.oREQ_RDATA, m_rdata);
            $display("txn req=%0d %s addr=%h wdata=%h rdata=%h err=%0d lat=%0d",
                     g, is_rd ? "RD" : "WR", m_addr[AW-1:0], m_wdata, bus.oREQ_RDATA,
                     bus.oREQ_ERR, is_rd ? lat : 0);
            if (is_rd && r_wr[g]) begin
               r_rd[g] = 1'b0;
            end else begin
               r_reps[g]--;
               if (r_reps[g] <= 0) begin
                  r_wr[g] = 1'b0;
                  r_rd[g] = 1'b0;
               end
            end
            drive_reqs();
            pend = r_wr | r_rd;
            if (pend != '0) exp_issue = t + (is_rd ? 2 : G + 2);
            else            tail_end  = t + (is_rd ? 7 : G + 4);
         end else begin
            check_eq("no_ack", bus.oREQ_ACK, '0);
            check_eq("err_idle", bus.oREQ_ERR, 1'b0);
            check_eq("rdata_hold", bus.oREQ_RDATA, m_rdata);
         end
         if (t == tail_end) break;
         @(negedge clk);
      end
      check_eq("round_done", t, tail_end);
      bus.iMM_RD_DATA_V = 1'b0;
   endtask

   task automatic random_reqs();
      clear_reqs();
      for (int i = 0; i < NREQ; i++) begin
         int kind;
         kind       = $urandom_range(0, 3);
         r_wr[i]    = (kind == 1) || (kind == 3);
         r_rd[i]    = (kind == 2) || (kind == 3);
         r_addr[i]  = AW'($urandom());
         r_wdata[i] = {$urandom(), $urandom()};
         r_reps[i]  = $urandom_range(1, 2);
      end
      if ((r_wr | r_rd) == '0) r_rd[0] = 1'b1;
   endtask

   initial begin
      bit seen;
      clear_reqs();
      drive_reqs();
      bus.iMM_RD_DATA_V = 1'b0;
      bus.iMM_RD_DATA   = '0;
      m_ptr = 0; m_rdata = '0; m_addr = '0; m_wdata = '0;

      repeat (3) @(negedge clk);
      check_eq("rst_ack", bus.oREQ_ACK, '0);
      check_eq("rst_strobe", {bus.oMM_WR_EN, bus.oMM_RD_EN}, 2'b00);
      check_eq("rst_busy", bus.oBUSY, 1'b0);
      check_eq("rst_rdata", bus.oREQ_RDATA, '0);
      rst = 1'b0;
      @(negedge clk);

      // Round robin: all requesters hold RD for two grants each, pointer at 0
      clear_reqs();
      r_rd = 3'b111;
      for (int i = 0; i < NREQ; i++) begin
         r_addr[i] = AW'(14'h0100 + i);
         r_reps[i] = 2;
      end
      gnt_log.delete();
      run_round(3);
      for (int i = 0; i < 6; i++) check_eq("rr_order", gnt_log[i], i % NREQ);

      // Single write from requester 1
      clear_reqs();
      r_wr[1] = 1'b1; r_addr[1] = 14'h0805; r_wdata[1] = 64'h1234;
      run_round(0);

      // Single read from requester 0 with 4-cycle decoder latency
      clear_reqs();
      r_rd[0] = 1'b1; r_addr[0] = 14'h0010;
      run_round(4);

      // Timeout, followed by a late RD_DATA_V that must be dropped
      clear_reqs();
      r_rd[2] = 1'b1; r_addr[2] = 14'h2ABC;
      run_round(T + 5);

      // Data arriving in the exact timeout cycle wins
      clear_reqs();
      r_rd[1] = 1'b1; r_addr[1] = 14'h1111;
      run_round(T);

      // WR+RD on one requester: read first, then the write
      clear_reqs();
      r_wr[2] = 1'b1; r_rd[2] = 1'b1; r_addr[2] = 14'h0042; r_wdata[2] = 64'hA5A5;
      gnt_log.delete();
      run_round(2);
      check_eq("wr_rd_count", gnt_log.size(), 2);

      for (int n = 0; n < 30; n++) begin
         random_reqs();
         run_round(0);
      end

      // Reset in the middle of RD_WAIT
      clear_reqs();
      r_rd[1] = 1'b1; r_addr[1] = 14'h0777;
      drive_reqs();
      seen = 0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         seen = bus.oMM_RD_EN;
      end
      check_eq("rst_test_issue", seen, 1'b1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("arst_ack", bus.oREQ_ACK, '0);
      check_eq("arst_err", bus.oREQ_ERR, 1'b0);
      check_eq("arst_rdata", bus.oREQ_RDATA, '0);
      check_eq("arst_strobe", {bus.oMM_WR_EN, bus.oMM_RD_EN}, 2'b00);
      check_eq("arst_addr", bus.oMM_ADDR, '0);
      check_eq("arst_wdata", bus.oMM_WR_DATA, '0);
      check_eq("arst_busy", bus.oBUSY, 1'b0);
      clear_reqs();
      drive_reqs();
      m_ptr = 0; m_rdata = '0; m_addr = '0; m_wdata = '0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      bus.iMM_RD_DATA_V = 1'b1;
      bus.iMM_RD_DATA   = 64'hBAD0_BAD0_BAD0_BAD0;
      @(negedge clk);
      bus.iMM_RD_DATA_V = 1'b0;
      for (int c = 0; c < 4; c++) begin
         check_eq("post_rst_ack", bus.oREQ_ACK, '0);
         check_eq("post_rst_busy", bus.oBUSY, 1'b0);
         check_eq("post_rst_rdata", bus.oREQ_RDATA, '0);
         @(negedge clk);
      end

      // Fresh arbitration after reset starts from pointer 0
      clear_reqs();
      r_rd = 3'b111;
      r_addr[0] = 14'h0001; r_addr[1] = 14'h0002; r_addr[2] = 14'h0003;
      gnt_log.delete();
      run_round(0);
      check_eq("post_rst_first_grant", gnt_log[0], 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
